// File: rtl/tt_io_bank_rr_arbiter.sv
// tt_io_bank_rr_arbiter: 4-way round-robin owner of the 8-bit lane bank with hold-time preemption; ARB_ACTIVE_LOW_OUT_EN inverts io_out
module tt_io_bank_rr_arbiter #(
  parameter int HOLD_MAX = 8
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);
  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
  logic clk, rst_n, lock, spare_unused;
  logic [3:0] req;
  assign clk = io_in[0];
  assign rst_n = io_in[1];
  assign req = io_in[5:2];
  assign lock = io_in[6];
  assign spare_unused = io_in[7];
  state_t state_q, state_d;
  logic [3:0] gnt_q, gnt_d, cnt_q, cnt_d;
  logic [1:0] idx_q, idx_d, ptr_q, ptr_d, win;
  logic to_q, to_d, rel, pre, others, arb;
  logic [7:0] out_int;
  // first requester at or after the priority pointer, wrapping
  always_comb begin
    win = ptr_q;
    for (int k = 3; k >= 0; k--) if (req[ptr_q + 2'(k)]) win = ptr_q + 2'(k);
  end
  // state and registered outputs, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q <= '0;
      idx_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
      to_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      idx_q <= idx_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      to_q <= to_d;
    end
  end
  // owner releases on drop, or is preempted when it overstays while others wait
  always_comb begin
    rel = !req[idx_q];
    others = |(req & ~(4'(1) << idx_q));
    pre = !rel && !lock && (cnt_q >= 4'(HOLD_MAX - 1)) && others;
    state_d = (state_q == GRANT) ? ((rel || pre) ? RELEASE : GRANT) : (|req ? GRANT : IDLE);
  end
  // next grant/index/pointer/counter values and pin mapping
  always_comb begin
    arb = (state_q != GRANT) && |req;
    gnt_d = (state_d == GRANT) ? (arb ? 4'(1) << win : gnt_q) : 4'b0;
    idx_d = arb ? win : idx_q;
    ptr_d = (state_q == GRANT && state_d == RELEASE) ? idx_q + 2'd1 : ptr_q;
    cnt_d = arb ? 4'd0 : (state_q == GRANT && cnt_q != 4'hF) ? cnt_q + 4'd1 : cnt_q;
    to_d = (state_q == GRANT) && pre;
    out_int = {to_q, state_q != IDLE, idx_q, gnt_q};
`ifdef ARB_ACTIVE_LOW_OUT_EN
    io_out = ~out_int;
`else
    io_out = out_int;
`endif
  end
endmodule

// File: doc/tt_io_bank_rr_arbiter.md
Name: tt_io_bank_rr_arbiter

Overview:
- Round-robin arbiter that shares the chip's 8-bit output lane bank among 4 requesters driven on the TinyTapeout input pins.
- Emits a registered one-hot grant, the owner index, a busy flag and a preemption pulse.
- Sits as a drop-in user module in the same 8-in/8-out scan-chain slot as the existing inverter-bank modules. It is the sequencer that decides which requester currently owns the bank.
- Preempts an owner that holds the grant too long while others wait, unless the owner asserts lock.

Parameters:
- HOLD_MAX, 8: max consecutive GRANT cycles before forced preemption when other requests are pending; legal 1..15.

Ports:
- io_in[0]  input  1  clock; all state on rising edge.
- io_in[1]  input  1  rst_n; reset, asynchronous assert, active-low. Low clears all state immediately.
- io_in[5:2]  input  4  req[3:0]; level requests; req[0] is io_in[2].
- io_in[6]  input  1  lock; while 1, current owner cannot be preempted.
- io_in[7]  input  1  unused; ignored.
- io_out[3:0]  output  4  gnt[3:0]; registered one-hot grant, 0 when nobody owns the bank.
- io_out[5:4]  output  2  idx; index of current or last owner.
- io_out[6]  output  1  busy; 1 when state != IDLE.
- io_out[7]  output  1  timeout; 1-cycle pulse marking a forced preemption.

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE, gnt=0, idx=0, busy=0, timeout=0.
  - Priority pointer ptr=0; hold counter cnt=0.
- Arbitration function:
  - Winner = first i with req[i]=1, searching i = ptr, ptr+1, ... mod 4.
- IDLE:
  - No req: stay; gnt=0.
  - Any req at edge N: state=GRANT from edge N; gnt=onehot(winner), idx=winner, cnt=0.
  - Latency: request sampled at an edge is granted on that edge's registered outputs (1 cycle from assertion).
- GRANT (owner o = idx):
  - cnt increments each edge and saturates at 15.
  - Normal release: req[o]=0 at an edge → RELEASE; gnt=0, ptr=o+1 mod 4, timeout=0.
  - Forced preemption: req[o]=1, lock=0, cnt>=HOLD_MAX-1, and any req[j]=1 with j!=o → RELEASE; gnt=0, ptr=o+1 mod 4, timeout=1 for that cycle.
  - lock=1 or no other request pending: no preemption; owner keeps grant indefinitely.
  - Release and preemption conditions both true in the same cycle → normal release, timeout=0.
- RELEASE:
  - Lasts exactly 1 cycle; gnt=0, busy=1.
  - Next edge: arbitrate using the updated ptr. Any req → GRANT (new winner, cnt=0); else → IDLE.
  - Dead gap between consecutive owners is exactly 1 cycle.
- Outputs:
  - idx retains the last owner in IDLE/RELEASE.
  - gnt is never more than one-hot.
  - timeout is 0 outside the RELEASE cycle that follows a preemption.
- Reset asserted mid-GRANT or mid-RELEASE: outputs drop to reset values without waiting for a clock edge. After release of reset, arbitration resumes from ptr=0.
- Width rules:
  - ptr and idx are 2-bit and wrap 3→0.
  - cnt is 4-bit, saturating.

Optional Feature:
- Macro ARB_ACTIVE_LOW_OUT_EN.
- Defined: io_out[7:0] drives the bitwise inverse of the internal outputs (active-low, matching the inverter-bank pin convention). Reset therefore shows io_out=8'hFF.
- Undefined: outputs are active-high as specified; reset shows io_out=8'h00.
- Internal state and timing are identical in both builds.

Test Plan:
- Reset: rst_n=0 with req=4'hF → io_out=8'h00 asynchronously, before any clock edge. Release reset, next edge → gnt=4'b0001, idx=0, busy=1.
- Round-robin: req=4'b0101 held and dropped by owner each grant → grant order req0, (gap), req2, (gap), req0. Each owner is separated by exactly 1 cycle with gnt=0.
- Preemption: HOLD_MAX=4, req0 and req3 held high, lock=0 → gnt=0001 for 4 cycles, then gnt=0 with timeout=1 for 1 cycle, then gnt=1000, idx=3.
- Lock: same stimulus with lock=1 → gnt=0001 for 20+ cycles, timeout never asserts. Drop lock → preemption on the next edge (cnt is saturated).
- Simultaneous: req0 drops on the same edge its preemption would fire → RELEASE with timeout=0; next grant goes to req1 if req1=1.
- Mid-op reset plus feature build: with ARB_ACTIVE_LOW_OUT_EN, assert rst_n=0 during GRANT → io_out=8'hFF immediately. After reset, winner search restarts at req0.
